data_memory: RTL and testbench

Word-addressed data memory with a small memory-mapped peripheral window, sitting directly downstream of the pipelined core's memory stage. It consumes the EX/MEM-registered ALU result as the address, the forwarded store data and the registered memory-write enable. It returns read data combinationally within the same cycle, so the core's MEM/WB register captures it. The peripheral window provides a general-purpose output register and a cycle timer with compare-match interrupt.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/data_memory_if.sv | 17 +
 rtl/data_memory_mmio_timer.sv | 91 +++++++++
 rtl/data_memory.sv | 87 ++++++++
 tb/tb_data_memory.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants for the data memory: peripheral window offsets, timer
// control bit positions and the address region select.
package riscv_mem_pkg;

   localparam logic [3:0] OFS_GPIO    = 4'h0;
   localparam logic [3:0] OFS_COUNT   = 4'h4;
   localparam logic [3:0] OFS_COMPARE = 4'h8;
   localparam logic [3:0] OFS_CTRL    = 4'hC;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_FLAG   = 2;
   localparam int CTRL_IRQEN  = 3;

   typedef enum logic [1:0] {RAM, MMIO, NONE} region_e;

endpackage

// File: rtl/data_memory_if.sv
// Memory-stage bus between the core and data_memory, plus the peripheral outputs.
interface data_memory_if #(parameter int WIDTH = 32);

   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] w_data;
   logic             write_en;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] gpio_out;
   logic             timer_irq;

   modport master (output address, w_data, write_en,
                   input  r_data, gpio_out, timer_irq);

   modport slave  (input  address, w_data, write_en,
                   output r_data, gpio_out, timer_irq);

endinterface

// File: rtl/data_memory_mmio_timer.sv
// Cycle timer with compare match, auto-reload and W1C match flag.
// Only instantiated when DATA_MEMORY_TIMER_EN is defined.
module mmio_timer
   import riscv_mem_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_count_i,
   input  logic             wr_compare_i,
   input  logic             wr_ctrl_i,
   input  logic [WIDTH-1:0] w_data_i,
   input  logic [3:0]       ofs_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             irq_o
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] compare_q, compare_d;
   logic             en_q, en_d;
   logic             reload_q, reload_d;
   logic             flag_q, flag_d;
   logic             irqen_q, irqen_d;
   logic             match;

   always_comb begin
      match     = en_q && (count_q == compare_q);
      count_d   = count_q;
      compare_d = compare_q;
      en_d      = en_q;
      reload_d  = reload_q;
      flag_d    = flag_q;
      irqen_d   = irqen_q;

      if (en_q) begin
         count_d = (match && reload_q) ? '0 : count_q + ONE;
      end
      if (wr_count_i) begin
         count_d = w_data_i;
      end
      if (wr_compare_i) begin
         compare_d = w_data_i;
      end
      if (wr_ctrl_i) begin
         en_d     = w_data_i[CTRL_EN];
         reload_d = w_data_i[CTRL_RELOAD];
         irqen_d  = w_data_i[CTRL_IRQEN];
         if (w_data_i[CTRL_FLAG]) begin
            flag_d = 1'b0;
         end
      end
      // a match in the same cycle beats the software clear
      if (match) begin
         flag_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q   <= '0;
         compare_q <= '0;
         en_q      <= 1'b0;
         reload_q  <= 1'b0;
         flag_q    <= 1'b0;
         irqen_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         en_q      <= en_d;
         reload_q  <= reload_d;
         flag_q    <= flag_d;
         irqen_q   <= irqen_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      case (ofs_i)
         OFS_COUNT:   rd_data_o = count_q;
         OFS_COMPARE: rd_data_o = compare_q;
         OFS_CTRL:    rd_data_o = WIDTH'({irqen_q, flag_q, reload_q, en_q});
         default:     rd_data_o = '0;
      endcase
   end

   assign irq_o = flag_q & irqen_q;

endmodule

// File: rtl/data_memory.sv
// Word-addressed data RAM plus a 16-byte peripheral window (GPIO_OUT and,
// when DATA_MEMORY_TIMER_EN is defined, the cycle timer). Reads are combinational.
module data_memory
   import riscv_mem_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 256,
   parameter logic [WIDTH-1:0] MMIO_BASE = 32'h0000_1000
) (
   input  logic         clock,
   input  logic         reset,
   data_memory_if.slave bus
);

   localparam int               AW        = $clog2(DEPTH);
   localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(DEPTH * 4);

   region_e          region;
   logic [3:0]       ofs;
   logic             mmio_wr;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] gpio_q, gpio_d;
   logic [WIDTH-1:0] timer_rd;
   logic             timer_irq_w;
   logic [WIDTH-1:0] r_data_w;

   always_comb begin
      region = NONE;
      if (bus.address < RAM_BYTES) begin
         region = RAM;
      end else if (bus.address[WIDTH-1:4] == MMIO_BASE[WIDTH-1:4]) begin
         region = MMIO;
      end
      ofs     = {bus.address[3:2], 2'b00};
      mmio_wr = bus.write_en && (region == MMIO);
      gpio_d  = gpio_q;
      if (mmio_wr && (ofs == OFS_GPIO)) begin
         gpio_d = bus.w_data;
      end
   end

   // RAM contents survive reset, so the array has no reset branch
   always_ff @(posedge clock) begin
      if (bus.write_en && (region == RAM)) begin
         mem_q[bus.address[AW+1:2]] <= bus.w_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gpio_q <= '0;
      end else begin
         gpio_q <= gpio_d;
      end
   end

`ifdef DATA_MEMORY_TIMER_EN
   mmio_timer #(.WIDTH(WIDTH)) u_timer (
      .clock        (clock),
      .reset        (reset),
      .wr_count_i   (mmio_wr && (ofs == OFS_COUNT)),
      .wr_compare_i (mmio_wr && (ofs == OFS_COMPARE)),
      .wr_ctrl_i    (mmio_wr && (ofs == OFS_CTRL)),
      .w_data_i     (bus.w_data),
      .ofs_i        (ofs),
      .rd_data_o    (timer_rd),
      .irq_o        (timer_irq_w)
   );
`else
   assign timer_rd    = '0;
   assign timer_irq_w = 1'b0;
`endif

   always_comb begin
      r_data_w = '0;
      case (region)
         RAM:     r_data_w = mem_q[bus.address[AW+1:2]];
         MMIO:    r_data_w = (ofs == OFS_GPIO) ? gpio_q : timer_rd;
         default: r_data_w = '0;
      endcase
   end

   assign bus.r_data    = r_data_w;
   assign bus.gpio_out  = gpio_q;
   assign bus.timer_irq = timer_irq_w;

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory; the RAM/GPIO reference is an
// array model, timer expectations are derived from elapsed-cycle arithmetic.
module tb_data_memory;

   localparam int          DEPTH = 256;
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [31:0] ram_m [DEPTH];
   logic [31:0] gpio_m;

   data_memory_if #(.WIDTH(32)) bus ();

   data_memory #(.WIDTH(32), .DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a < DEPTH * 4) return ram_m[a[AW+1:2]];
      if (a[31:4] == BASE[31:4] && a[3:2] == 2'd0) return gpio_m;
      return 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.address  = a;
      bus.w_data   = d;
      bus.write_en = 1'b1;
      @(posedge clk);
      #1;
      bus.write_en = 1'b0;
      if (a < DEPTH * 4) ram_m[a[AW+1:2]] = d;
      else if (a[31:4] == BASE[31:4] && a[3:2] == 2'd0) gpio_m = d;
   endtask

   task automatic test_reset();
      bus.address = BASE;
      #1;
      checks++;
      if (bus.gpio_out !== 32'h0) begin
         errors++; $display("FAIL reset_gpio: got %h want %h", bus.gpio_out, 32'h0);
      end
      checks++;
      if (bus.timer_irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq: got %b want 0", bus.timer_irq);
      end
      for (int o = 0; o < 4; o++) begin
         bus.address = BASE + 32'(o * 4);
         #1;
         checks++;
         if (bus.r_data !== 32'h0) begin
            errors++; $display("FAIL reset_reg%0d: got %h want 0", o, bus.r_data);
         end
      end
   endtask

   task automatic test_ram_fill();
      for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom);
      for (int i = 0; i < DEPTH; i++) begin
         bus.address = 32'(i * 4) | 32'($urandom_range(0, 3));
         #1;
         checks++;
         if (bus.r_data !== ram_m[i]) begin
            errors++; $display("FAIL ram_fill[%0d]: got %h want %h", i, bus.r_data, ram_m[i]);
         end
      end
   endtask

   task automatic test_ram_plan();
      logic [31:0] a;
      wr(32'h10, 32'hDEAD_BEEF);
      a = 32'h10;
      for (int k = 0; k < 3; k++) begin
         bus.address = a;
         #1;
         checks++;
         if (bus.r_data !== model_rd(a)) begin
            errors++; $display("FAIL ram_plan@%h: got %h want %h", a, bus.r_data, model_rd(a));
         end
         a = (k == 0) ? 32'h13 : 32'h14;
      end
      checks++;
      if (model_rd(32'h13) !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL ram_plan_model: got %h want DEADBEEF", model_rd(32'h13));
      end
      bus.address = DEPTH * 4;
      #1;
      checks++;
      if (bus.r_data !== 32'h0) begin
         errors++; $display("FAIL ram_plan_oob: got %h want 0", bus.r_data);
      end
   endtask

   task automatic test_random_mix();
      logic [31:0] a, d;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            a = $urandom_range(DEPTH * 4, 32'hFFFF);
            if ($urandom_range(0, 1) == 1) a = $urandom;
            if (a[31:4] == BASE[31:4]) a = a ^ 32'h8000_0000;
         end else begin
            a = $urandom_range(0, DEPTH * 4 - 1);
         end
         d = $urandom;
         if ($urandom_range(0, 1) == 1) wr(a, d);
         bus.address = a;
         #1;
         checks++;
         if (bus.r_data !== model_rd(a)) begin
            errors++; $display("FAIL rand_rd@%h: got %h want %h", a, bus.r_data, model_rd(a));
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         bus.address = 32'(i * 4);
         #1;
         checks++;
         if (bus.r_data !== ram_m[i]) begin
            errors++; $display("FAIL rand_sweep[%0d]: got %h want %h", i, bus.r_data, ram_m[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] old_v, new_v;
      old_v = ram_m[16];
      new_v = ~old_v;
      bus.address  = 32'h40;
      bus.w_data   = new_v;
      bus.write_en = 1'b1;
      #1;
      checks++;
      if (bus.r_data !== old_v) begin
         errors++; $display("FAIL same_cycle_old: got %h want %h", bus.r_data, old_v);
      end
      tick();
      bus.write_en = 1'b0;
      ram_m[16] = new_v;
      checks++;
      if (bus.r_data !== new_v) begin
         errors++; $display("FAIL same_cycle_new: got %h want %h", bus.r_data, new_v);
      end
   endtask

   task automatic test_gpio();
      bus.address  = BASE;
      bus.w_data   = 32'hA5;
      bus.write_en = 1'b1;
      #1;
      checks++;
      if (bus.gpio_out !== gpio_m) begin
         errors++; $display("FAIL gpio_pre_edge: got %h want %h", bus.gpio_out, gpio_m);
      end
      tick();
      bus.write_en = 1'b0;
      gpio_m = 32'hA5;
      checks++;
      if (bus.gpio_out !== 32'hA5) begin
         errors++; $display("FAIL gpio_out: got %h want %h", bus.gpio_out, 32'hA5);
      end
      checks++;
      if (bus.r_data !== 32'hA5) begin
         errors++; $display("FAIL gpio_rd: got %h want %h", bus.r_data, 32'hA5);
      end
      #2 rst_n = 1'b0;
      gpio_m = 32'h0;
      #1;
      checks++;
      if (bus.gpio_out !== 32'h0) begin
         errors++; $display("FAIL gpio_async_rst: got %h want 0", bus.gpio_out);
      end
      bus.address = 32'h10;
      #1;
      checks++;
      if (bus.r_data !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL ram_retained: got %h want DEADBEEF", bus.r_data);
      end
      #1 rst_n = 1'b1;
      tick();
   endtask

`ifdef DATA_MEMORY_TIMER_EN
   task automatic timer_stop();
      wr(BASE + 32'hC, 32'h0);
      wr(BASE + 32'hC, 32'h4);
      wr(BASE + 32'h4, 32'h0);
   endtask

   task automatic test_timer_reload();
      logic [31:0] exp_ctrl;
      int          seq [6];
      wr(BASE + 32'h8, 32'd3);
      wr(BASE + 32'hC, 32'hB);
      bus.address = BASE + 32'h4;
      #1;
      checks++;
      if (bus.r_data !== 32'd0) begin
         errors++; $display("FAIL tmr_en_edge: got %0d want 0", bus.r_data);
      end
      seq = '{0, 1, 2, 3, 0, 1};
      for (int k = 1; k <= 5; k++) begin
         tick();
         bus.address = BASE + 32'h4;
         #1;
         checks++;
         if (bus.r_data !== 32'(seq[k])) begin
            errors++; $display("FAIL tmr_seq k=%0d: got %0d want %0d", k, bus.r_data, seq[k]);
         end
         checks++;
         if (bus.timer_irq !== (k >= 4)) begin
            errors++; $display("FAIL tmr_irq k=%0d: got %b want %b", k, bus.timer_irq, k >= 4);
         end
      end
      // count=1: clear, step to 3, clear on match (match wins), rewrite 0xB, clear
      for (int s = 0; s < 5; s++) begin
         case (s)
            0: begin wr(BASE + 32'hC, 32'hF); exp_ctrl = 32'hB; end
            1: begin tick();                  exp_ctrl = 32'hB; end
            2: begin wr(BASE + 32'hC, 32'hF); exp_ctrl = 32'hF; end
            3: begin wr(BASE + 32'hC, 32'hB); exp_ctrl = 32'hF; end
            default: begin wr(BASE + 32'hC, 32'hF); exp_ctrl = 32'hB; end
         endcase
         bus.address = BASE + 32'hC;
         #1;
         checks++;
         if (bus.r_data !== exp_ctrl) begin
            errors++; $display("FAIL tmr_ctrl s=%0d: got %h want %h", s, bus.r_data, exp_ctrl);
         end
         checks++;
         if (bus.timer_irq !== exp_ctrl[2]) begin
            errors++; $display("FAIL tmr_w1c_irq s=%0d: got %b want %b", s, bus.timer_irq, exp_ctrl[2]);
         end
      end
      timer_stop();
   endtask

   task automatic test_timer_random();
      int c;
      for (int r = 0; r < 3; r++) begin
         c = $urandom_range(1, 6);
         wr(BASE + 32'h8, 32'(c));
         wr(BASE + 32'hC, 32'hB);
         for (int k = 1; k <= 3 * (c + 1); k++) begin
            tick();
            bus.address = BASE + 32'h4;
            #1;
            checks++;
            if (bus.r_data !== 32'(k % (c + 1))) begin
               errors++; $display("FAIL tmr_rand c=%0d k=%0d: got %0d want %0d", c, k, bus.r_data, k % (c + 1));
            end
            checks++;
            if (bus.timer_irq !== (k >= c + 1)) begin
               errors++; $display("FAIL tmr_rand_irq c=%0d k=%0d: got %b", c, k, bus.timer_irq);
            end
         end
         timer_stop();
      end
   endtask

   task automatic test_timer_noreload();
      wr(BASE + 32'h8, 32'd2);
      wr(BASE + 32'hC, 32'h1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         bus.address = BASE + 32'h4;
         #1;
         checks++;
         if (bus.r_data !== 32'(k)) begin
            errors++; $display("FAIL tmr_norl k=%0d: got %0d want %0d", k, bus.r_data, k);
         end
         bus.address = BASE + 32'hC;
         #1;
         checks++;
         if (bus.r_data !== ((k >= 3) ? 32'h5 : 32'h1)) begin
            errors++; $display("FAIL tmr_norl_ctrl k=%0d: got %h", k, bus.r_data);
         end
         checks++;
         if (bus.timer_irq !== 1'b0) begin
            errors++; $display("FAIL tmr_norl_irq k=%0d: got %b want 0", k, bus.timer_irq);
         end
      end
      timer_stop();
   endtask

   task automatic test_timer_wrap();
      logic [31:0] exp_v [4];
      exp_v = '{32'hFFFF_FFFF, 32'h0, 32'h1234, 32'h1235};
      wr(BASE + 32'h8, 32'd100);
      wr(BASE + 32'hC, 32'h1);
      for (int s = 0; s < 4; s++) begin
         case (s)
            0: wr(BASE + 32'h4, 32'hFFFF_FFFF);
            2: wr(BASE + 32'h4, 32'h1234);
            default: tick();
         endcase
         bus.address = BASE + 32'h4;
         #1;
         checks++;
         if (bus.r_data !== exp_v[s]) begin
            errors++; $display("FAIL tmr_wrap s=%0d: got %h want %h", s, bus.r_data, exp_v[s]);
         end
      end
      timer_stop();
   endtask

   task automatic test_timer_async_reset();
      wr(BASE + 32'h8, 32'd2);
      wr(BASE + 32'hC, 32'hB);
      for (int k = 0; k < 4; k++) tick();
      checks++;
      if (bus.timer_irq !== 1'b1) begin
         errors++; $display("FAIL tmr_pre_rst_irq: got %b want 1", bus.timer_irq);
      end
      #2 rst_n = 1'b0;
      gpio_m = 32'h0;
      #1;
      checks++;
      if (bus.timer_irq !== 1'b0) begin
         errors++; $display("FAIL tmr_rst_irq: got %b want 0", bus.timer_irq);
      end
      bus.address = BASE + 32'h4;
      #1;
      checks++;
      if (bus.r_data !== 32'h0) begin
         errors++; $display("FAIL tmr_rst_count: got %h want 0", bus.r_data);
      end
      #1 rst_n = 1'b1;
      tick();
   endtask
`else
   task automatic test_no_timer();
      wr(BASE + 32'h8, 32'd5);
      wr(BASE + 32'h4, 32'd7);
      wr(BASE + 32'hC, 32'hF);
      for (int k = 0; k < 4; k++) tick();
      for (int o = 1; o < 4; o++) begin
         bus.address = BASE + 32'(o * 4);
         #1;
         checks++;
         if (bus.r_data !== 32'h0) begin
            errors++; $display("FAIL no_timer_rd%0d: got %h want 0", o, bus.r_data);
         end
      end
      checks++;
      if (bus.timer_irq !== 1'b0) begin
         errors++; $display("FAIL no_timer_irq: got %b want 0", bus.timer_irq);
      end
      checks++;
      if (bus.gpio_out !== gpio_m) begin
         errors++; $display("FAIL no_timer_gpio: got %h want %h", bus.gpio_out, gpio_m);
      end
   endtask
`endif

   initial begin
      checks       = 0;
      errors       = 0;
      gpio_m       = 32'h0;
      rst_n        = 1'b0;
      bus.address  = 32'h0;
      bus.w_data   = 32'h0;
      bus.write_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) ram_m[i] = 32'h0;
      #7;
      test_reset();
      rst_n = 1'b1;
      tick();
      test_ram_fill();
      test_ram_plan();
      test_random_mix();
      test_back_to_back();
      test_gpio();
`ifdef DATA_MEMORY_TIMER_EN
      test_timer_reload();
      test_timer_random();
      test_timer_noreload();
      test_timer_wrap();
      test_timer_async_reset();
`else
      test_no_timer();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
